// File: rtl/uart_pkg.sv
// Shared UART definitions: 8N1 frame constants and the receiver state encoding.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned BIT_IDX_W = 3;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Consumer-side bundle of the UART receiver: byte stream handshake plus error pulses.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rvalid;
    logic                 rready;
    logic [DATA_BITS-1:0] rdata;
    logic                 frame_err;
    logic                 overflow;

    modport master (output rvalid, output rdata, output frame_err, output overflow, input rready);
    modport slave  (input rvalid, input rdata, input frame_err, input overflow, output rready);

endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive buffer with first-word fall-through head; storage has no reset.
module uart_rx_fifo #(
    parameter int unsigned FIFO_ASIZE = 4,
    parameter int unsigned DW         = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int unsigned DEPTH = 1 << FIFO_ASIZE;
    localparam int unsigned PTR_W = FIFO_ASIZE + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [DW-1:0]    mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A full buffer still accepts a push when the head leaves in the same cycle.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[PTR_W-1] != rptr_q[PTR_W-1]) &&
                  (wptr_q[PTR_W-2:0] == rptr_q[PTR_W-2:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = do_push ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + PTR_W'(1) : rptr_q;
        rdata   = empty ? '0 : mem[rptr_q[PTR_W-2:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q[PTR_W-2:0]] <= wdata;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes the line, samples mid-bit and buffers bytes in a FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned UART_CLK_DIV = 868,
    parameter int unsigned FIFO_ASIZE   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_uart_rx,
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DATA_BITS-1:0] rdata,
    output logic                 frame_err,
    output logic                 overflow
);

    localparam int unsigned CNT_W     = $clog2(UART_CLK_DIV);
    localparam int unsigned HALF_LAST = UART_CLK_DIV / 2 - 1;
    localparam int unsigned FULL_LAST = UART_CLK_DIV - 1;

    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overflow_q, overflow_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 pop_c;

    // Frame FSM: start is validated at half a bit, data and stop at each bit centre.
    always_comb begin
        rx_meta_d   = i_uart_rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d = RX_START;
                end
            end
            RX_START: begin
                if (cnt_q == CNT_W'(HALF_LAST)) begin
                    cnt_d   = '0;
                    state_d = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CNT_W'(FULL_LAST)) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
                    if (bit_idx_q == BIT_IDX_W'(DATA_BITS - 1)) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CNT_W'(FULL_LAST)) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_d  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    // A registered push that finds the buffer full and not draining is dropped.
    always_comb begin
        pop_c      = rready && !fifo_empty;
        overflow_d = push_q && fifo_full && !pop_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= RX_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    uart_rx_fifo #(
        .FIFO_ASIZE (FIFO_ASIZE),
        .DW         (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata (shift_q),
        .pop   (pop_c),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rvalid    = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit with a 4-entry buffer.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned DIV = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic line;

    uart_rx_if bus ();

    uart_rx #(
        .UART_CLK_DIV (DIV),
        .FIFO_ASIZE   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_uart_rx (line),
        .rvalid    (bus.rvalid),
        .rready    (bus.rready),
        .rdata     (bus.rdata),
        .frame_err (bus.frame_err),
        .overflow  (bus.overflow)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         fe_cnt   = 0;
    int         ov_cnt   = 0;
    int         rv_rise  = 0;
    logic       rv_prev  = 1'b0;
    logic [7:0] popped [$];

    // Observe the consumer side between clock edges.
    always @(negedge clk) begin
        if (bus.rvalid && bus.rready) popped.push_back(bus.rdata);
        if (bus.frame_err) fe_cnt++;
        if (bus.overflow) ov_cnt++;
        if (bus.rvalid && !rv_prev) rv_rise++;
        rv_prev = bus.rvalid;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line is left at the stop-bit level when the frame ends.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        line = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            tick(DIV);
        end
        line = stop;
        tick(DIV);
    endtask

    int   base_pop, base_fe, base_ov, base_rise;
    logic got_push;

    initial begin
        rst_n      = 1'b0;
        line       = 1'b1;
        bus.rready = 1'b0;
        tick(4);
        check("reset_rvalid", 32'(bus.rvalid), 32'd0);
        check("reset_rdata", 32'(bus.rdata), 32'h00);
        check("reset_frame_err", 32'(bus.frame_err), 32'd0);
        check("reset_overflow", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        tick(8);

        // Two good bytes, consumer always ready.
        bus.rready = 1'b1;
        base_pop = popped.size(); base_fe = fe_cnt; base_rise = rv_rise;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        tick(20);
        check("b2b_pop_count", 32'(popped.size() - base_pop), 32'd2);
        check("b2b_byte0", 32'(popped[base_pop]), 32'h55);
        check("b2b_byte1", 32'(popped[base_pop + 1]), 32'hA3);
        check("b2b_rvalid_pulses", 32'(rv_rise - base_rise), 32'd2);
        check("b2b_frame_err", 32'(fe_cnt - base_fe), 32'd0);

        // Short low glitch must be rejected.
        base_pop = popped.size(); base_fe = fe_cnt; base_rise = rv_rise;
        line = 1'b0;
        tick(5);
        line = 1'b1;
        tick(3 * DIV);
        check("glitch_state", 32'(dut.state_q), 32'(RX_IDLE));
        check("glitch_rvalid_pulses", 32'(rv_rise - base_rise), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt - base_fe), 32'd0);

        // Low stop bit followed by a long break.
        base_pop = popped.size(); base_fe = fe_cnt; base_ov = ov_cnt;
        send_frame(8'h3C, 1'b0);
        tick(40 * DIV);
        line = 1'b1;
        tick(3 * DIV);
        check("break_frame_err", 32'(fe_cnt - base_fe), 32'd1);
        check("break_no_byte", 32'(popped.size() - base_pop), 32'd0);
        check("break_rvalid", 32'(bus.rvalid), 32'd0);
        check("break_overflow", 32'(ov_cnt - base_ov), 32'd0);

        // Five bytes into a four-entry buffer with no consumer.
        bus.rready = 1'b0;
        base_pop = popped.size(); base_ov = ov_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        tick(40);
        check("ovf_pulses", 32'(ov_cnt - base_ov), 32'd1);
        check("ovf_rvalid", 32'(bus.rvalid), 32'd1);
        check("ovf_head", 32'(bus.rdata), 32'h01);
        bus.rready = 1'b1;
        tick(8);
        bus.rready = 1'b0;
        check("ovf_drain_count", 32'(popped.size() - base_pop), 32'd4);
        for (int i = 0; i < 4; i++) check("ovf_drain_byte", 32'(popped[base_pop + i]), 32'(i + 1));
        check("ovf_empty", 32'(bus.rvalid), 32'd0);

        // Fill the buffer, then pop exactly on the push cycle of a fifth byte.
        base_pop = popped.size(); base_ov = ov_cnt;
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        tick(20);
        check("full_head", 32'(bus.rdata), 32'h10);
        got_push = 1'b0;
        fork
            send_frame(8'h14, 1'b1);
            begin
                for (int i = 0; i < 400 && !got_push; i++) begin
                    tick(1);
                    if (dut.push_q) got_push = 1'b1;
                end
                if (got_push) begin
                    bus.rready = 1'b1;
                    tick(1);
                    bus.rready = 1'b0;
                end
            end
        join
        tick(20);
        check("full_push_seen", 32'(got_push), 32'd1);
        check("full_no_overflow", 32'(ov_cnt - base_ov), 32'd0);
        check("full_one_popped", 32'(popped.size() - base_pop), 32'd1);
        check("full_new_head", 32'(bus.rdata), 32'h11);
        bus.rready = 1'b1;
        tick(10);
        bus.rready = 1'b0;
        check("full_drain_count", 32'(popped.size() - base_pop), 32'd5);
        for (int i = 1; i < 5; i++) check("full_drain_byte", 32'(popped[base_pop + i]), 32'h10 + 32'(i));

        // Reset in the middle of 0xFF with a byte already buffered.
        send_frame(8'h77, 1'b1);
        tick(20);
        check("pre_reset_head", 32'(bus.rdata), 32'h77);
        base_pop = popped.size(); base_fe = fe_cnt;
        line = 1'b0;
        tick(DIV);
        line = 1'b1;
        tick(4 * DIV + DIV / 2);
        rst_n = 1'b0;
        tick(3);
        check("mid_reset_rvalid", 32'(bus.rvalid), 32'd0);
        check("mid_reset_rdata", 32'(bus.rdata), 32'h00);
        rst_n = 1'b1;
        tick(6 * DIV);
        check("post_reset_empty", 32'(bus.rvalid), 32'd0);
        bus.rready = 1'b1;
        send_frame(8'h42, 1'b1);
        tick(20);
        check("post_reset_count", 32'(popped.size() - base_pop), 32'd1);
        check("post_reset_byte", 32'(popped[base_pop]), 32'h42);
        check("post_reset_frame_err", 32'(fe_cnt - base_fe), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter UART_CLK_DIV, default 868, meaning clk cycles per UART bit (868 gives 115200 baud at 100 MHz); legal range is >= 8.
REQ-002 SHALL have parameter FIFO_ASIZE, default 4, meaning receive buffer depth of 2^FIFO_ASIZE bytes.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_uart_rx, input, 1 bit: serial line from host TXD, asynchronous to clk, idle high.
REQ-006 SHALL have port rvalid, output, 1 bit: a byte is available at the buffer head.
REQ-007 SHALL have port rready, input, 1 bit: the consumer accepts the head byte.
REQ-008 SHALL have port rdata, output, 8 bits: the buffer head byte, valid while rvalid=1.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a stop bit is sampled low.
REQ-010 SHALL have port overflow, output, 1 bit: one-cycle pulse when a good byte is dropped because the buffer is full.

Function
REQ-011 SHALL pass i_uart_rx through a 2-flop synchronizer with both flops reset to 1; all line decisions SHALL use the synchronized value rx_s.
REQ-012 SHALL implement the states IDLE, START, DATA, STOP and WAIT_HIGH, with one bit-period counter and one 3-bit bit index.
REQ-013 In IDLE, rx_s=0 SHALL move the block to START with the counter cleared.
REQ-014 In START, at counter = UART_CLK_DIV/2-1 (integer division), rx_s=1 SHALL return to IDLE with a glitch reject and no pulse; rx_s=0 SHALL move to DATA with the counter cleared.
REQ-015 In DATA, each time the counter reaches UART_CLK_DIV-1 the block SHALL sample rx_s into the shift register LSB first; after the 8th sample it SHALL move to STOP.
REQ-016 In STOP, when the counter reaches UART_CLK_DIV-1 and rx_s=1, the block SHALL push the byte and go directly to IDLE, which permits back-to-back frames with no idle gap.
REQ-017 In STOP, when the counter reaches UART_CLK_DIV-1 and rx_s=0, the block SHALL pulse frame_err, discard the byte, and go to WAIT_HIGH.
REQ-018 In WAIT_HIGH, rx_s=1 SHALL move the block to IDLE; a held-low (break) line SHALL produce exactly one frame_err.
REQ-019 The push SHALL occur on the cycle after the stop-bit sample, and rvalid SHALL rise on the cycle after the push, from an empty buffer.
REQ-020 The buffer SHALL be a circular FIFO with (FIFO_ASIZE+1)-bit read and write pointers that wrap modulo 2^(FIFO_ASIZE+1).
REQ-021 The buffer SHALL be empty when the pointers are equal, and full when the MSBs differ and the remaining bits are equal.
REQ-022 A pop SHALL occur when rvalid=1 and rready=1; rready while empty SHALL be ignored.
REQ-023 A push SHALL be accepted when the buffer is not full or a pop occurs in the same cycle; otherwise the byte SHALL be dropped and overflow SHALL pulse.
REQ-024 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-025 rdata SHALL always reflect the current head entry, with first-word fall-through and no extra read latency.

Reset
REQ-026 While rst_n=0, the block SHALL force state IDLE, counter 0, bit index 0, and shift register 0.
REQ-027 While rst_n=0, the block SHALL force both FIFO pointers to 0, rvalid=0, rdata=0, frame_err=0, overflow=0, and both synchronizer flops to 1.
REQ-028 Reset during a frame SHALL abandon that frame; after release, the remainder of the frame SHALL NOT produce a byte unless it contains a falling edge that forms a valid frame.

Structure
REQ-029 The receiver state enumeration and the 8N1 frame constants (data bits = 8, stop bits = 1) SHALL live in shared package uart_pkg, which uart_tx also uses.
REQ-030 The buffer SHALL be the sub-module uart_rx_fifo, parameterized by FIFO_ASIZE and 8-bit data width, with push/pop/full/empty ports.
REQ-031 Buffer storage SHALL be inferable as distributed RAM or BRAM, with no reset on the storage array.

Verification (UART_CLK_DIV=16, FIFO_ASIZE=2)
REQ-032 Send 0x55, then 0xA3, with rready=1: rvalid SHALL pulse twice with rdata 0x55 then 0xA3, and frame_err=0.
REQ-033 Drive a 5-cycle low glitch on the idle line: the block SHALL return to IDLE with no rvalid and no frame_err.
REQ-034 Send 0x3C with the stop bit driven low, then hold the line low for 40 bit times: frame_err SHALL pulse exactly once, with no byte pushed.
REQ-035 With rready=0, send 0x01 through 0x05 back-to-back: the first four bytes SHALL be buffered, overflow SHALL pulse once on 0x05, and asserting rready SHALL yield 0x01..0x04 in order.
REQ-036 With the buffer full and rready=1 at the push cycle of a 5th byte, the byte SHALL be accepted, no overflow SHALL occur, and the occupancy SHALL stay at 4.
REQ-037 Assert rst_n=0 at data bit 4 of 0xFF, release it, then send 0x42: the only byte output SHALL be 0x42, and the buffer SHALL be empty after the reset.
